// File: rtl/util_axis_string_pkg.sv
// Shared definitions for the AXIS string path: FSM state encoding and ASCII constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package util_axis_string_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_TERM_CR = 2'd2,
        ST_TERM_LF = 2'd3
    } str_state_e;

    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

    // Counter width for an index over n characters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/util_axis_byte_slot.sv
// Single registered AXIS byte output slot (tdata/tvalid/tlast) with hold logic.
// Latency: a byte loaded on an edge is presented right after that edge.
// Backpressure: contents frozen while tvalid & ~tready; free_o tells the producer when a load is allowed.
module util_axis_byte_slot (
    input  logic       aclk,
    input  logic       arstn,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    output logic       free_o,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready
);

    logic [7:0] tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;

    // Slot can take a new byte when empty or when its current byte leaves this cycle.
    assign free_o = ~tvalid_q | m_axis_tready;

    // Next slot contents: load wins, otherwise drain when consumed, otherwise hold.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (load_i) begin
            tdata_d  = data_i;
            tlast_d  = last_i;
            tvalid_d = 1'b1;
        end else if (free_o) begin
            tvalid_d = 1'b0;
        end
    end

    // Slot registers; reset empties the slot immediately.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: rtl/util_axis_string_serializer.sv
// Serializes a STRING_BYTES character word into an AXIS byte stream, char 0 first, optional NUL drop and CR/LF.
// Latency: first byte valid 1 cycle after the input handshake, +1 per leading skipped NUL; then 1 byte/cycle.
// Backpressure: input accepted only in IDLE; output slot holds its byte while m_axis_tready is low.
module util_axis_string_serializer
    import util_axis_string_pkg::*;
#(
    parameter int STRING_BYTES = 11,
    parameter int APPEND_CRLF  = 1,
    parameter int SKIP_NULL    = 1
) (
    input  logic                      aclk,
    input  logic                      arstn,
    input  logic [STRING_BYTES*8-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [7:0]                m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int              WORD_W   = STRING_BYTES * 8;
    localparam int              IDX_W    = idx_width(STRING_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRING_BYTES - 1);
    localparam bit              CRLF_ON  = (APPEND_CRLF != 0);
    localparam bit              SKIP_ON  = (SKIP_NULL != 0);

    str_state_e        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              s_tready_q, s_tready_d;

    logic              slot_free;
    logic              slot_load;
    logic [7:0]        slot_data;
    logic              slot_last;

    // The character under examination is always the top byte; the word shifts left as it is consumed.
    logic [7:0] cur_char;
    logic       cur_is_last;
    logic       forced_last;
    logic       cur_skip;
    logic       in_hs;

    assign cur_char    = shift_q[WORD_W-1 -: 8];
    assign cur_is_last = (idx_q == LAST_IDX);
    // Without a terminator the final character carries tlast, so it must always be emitted.
    assign forced_last = cur_is_last & ~CRLF_ON;
    assign cur_skip    = SKIP_ON & (cur_char == CHAR_NUL) & ~forced_last;
    assign in_hs       = s_axis_tvalid & s_tready_q;

    // Next-state, word shifter, index and slot load control.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        s_tready_d = s_tready_q;
        slot_load  = 1'b0;
        slot_data  = cur_char;
        slot_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_tready_d = 1'b1;
                if (in_hs) begin
                    shift_d    = s_axis_tdata;
                    idx_d      = '0;
                    state_d    = ST_SEND;
                    s_tready_d = 1'b0;
                end
            end
            ST_SEND: begin
                s_tready_d = 1'b0;
                if (slot_free) begin
                    if (!cur_skip) begin
                        slot_load = 1'b1;
                        slot_data = cur_char;
                        slot_last = forced_last;
                    end
                    if (cur_is_last) begin
                        // Index saturates here; the word is finished once this char is handled.
                        state_d    = CRLF_ON ? ST_TERM_CR : ST_IDLE;
                        s_tready_d = ~CRLF_ON;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q << 8;
                    end
                end
            end
            ST_TERM_CR: begin
                s_tready_d = 1'b0;
                if (slot_free) begin
                    slot_load = 1'b1;
                    slot_data = CHAR_CR;
                    slot_last = 1'b0;
                    state_d   = ST_TERM_LF;
                end
            end
            ST_TERM_LF: begin
                s_tready_d = 1'b0;
                if (slot_free) begin
                    slot_load  = 1'b1;
                    slot_data  = CHAR_LF;
                    slot_last  = 1'b1;
                    state_d    = ST_IDLE;
                    s_tready_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                s_tready_d = 1'b0;
            end
        endcase
    end

    // State, word, index and input-ready registers; reset discards any partial string.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            s_tready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            s_tready_q <= s_tready_d;
        end
    end

    assign s_axis_tready = s_tready_q;

    util_axis_byte_slot u_slot (
        .aclk          (aclk),
        .arstn         (arstn),
        .load_i        (slot_load),
        .data_i        (slot_data),
        .last_i        (slot_last),
        .free_o        (slot_free),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_util_axis_string_serializer.sv
// Directed bench for util_axis_string_serializer: default instance plus a no-terminator instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_util_axis_string_serializer;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;

    // Default instance (CR/LF appended, NULs skipped).
    logic [87:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;

    // No-terminator instance.
    logic [87:0] b_s_tdata = '0;
    logic        b_s_tvalid = 1'b0;
    logic        b_s_tready;
    logic [7:0]  b_m_tdata;
    logic        b_m_tvalid;
    logic        b_m_tready = 1'b1;
    logic        b_m_tlast;

    always #5 aclk = ~aclk;

    util_axis_string_serializer dut (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast)
    );

    util_axis_string_serializer #(.STRING_BYTES(11), .APPEND_CRLF(0), .SKIP_NULL(1)) dut_b (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .m_axis_tlast(b_m_tlast)
    );

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    logic drop = 1'b0;

    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] rx_d[$];
    logic       rx_l[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bytes for one word through the default instance.
    task automatic model_push(input logic [87:0] w);
        logic [7:0] c;
        for (int k = 0; k < 11; k++) begin
            c = w[(10-k)*8 +: 8];
            if (c != 8'h00) begin
                exp_d.push_back(c);
                exp_l.push_back(1'b0);
            end
        end
        exp_d.push_back(8'h0D); exp_l.push_back(1'b0);
        exp_d.push_back(8'h0A); exp_l.push_back(1'b1);
    endtask

    // One cycle from a negedge to the next, counting input handshakes and dropping tvalid after one.
    task automatic step();
        if (s_tvalid && s_tready) begin
            hs++;
            drop = 1'b1;
        end
        @(negedge aclk);
        if (drop) begin
            s_tvalid = 1'b0;
            drop = 1'b0;
        end
    endtask

    // Collect one string from the default instance with m_tready high, bounded.
    task automatic collect_string(input int max_cyc);
        logic done;
        done = 1'b0;
        rx_d.delete(); rx_l.delete();
        for (int c = 0; c < max_cyc && !done; c++) begin
            step();
            if (m_tvalid) begin
                rx_d.push_back(m_tdata);
                rx_l.push_back(m_tlast);
                if (m_tlast) done = 1'b1;
            end
        end
        chk("collect_tlast_seen", 32'(done), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_count"}, 32'(rx_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            chk({tag, "_data"}, 32'(rx_d[i]), 32'(exp_d[i]));
            chk({tag, "_last"}, 32'(rx_l[i]), 32'(exp_l[i]));
        end
    endtask

    logic [87:0] w1, w2, w3, wz;
    logic [7:0]  e1[13];

    initial begin
        w1 = "0123456789A";
        w2 = 88'h00_00_00_41_42_00_43_00_00_00_44;
        w3 = "HELLOWORLD!";
        wz = '0;
        for (int i = 0; i < 11; i++) e1[i] = w1[(10-i)*8 +: 8];
        e1[11] = 8'h0D;
        e1[12] = 8'h0A;

        // Reset state.
        repeat (2) @(negedge aclk);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata",  32'(m_tdata),  32'd0);
        chk("rst_m_tlast",  32'(m_tlast),  32'd0);
        chk("rst_b_m_tvalid", 32'(b_m_tvalid), 32'd0);
        arstn = 1'b1;
        #1;
        chk("rel_s_tready_before_edge", 32'(s_tready), 32'd0);
        @(negedge aclk);
        chk("rel_s_tready_after_edge", 32'(s_tready), 32'd1);
        chk("rel_b_s_tready_after_edge", 32'(b_s_tready), 32'd1);

        // Word "0123456789A": 13 consecutive bytes, second word held during SEND.
        s_tdata = w1; s_tvalid = 1'b1;
        step();
        chk("t1_hs", 32'(hs), 32'd1);
        chk("t1_no_valid_yet", 32'(m_tvalid), 32'd0);
        chk("t1_s_tready_low", 32'(s_tready), 32'd0);
        s_tdata = w2; s_tvalid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            chk("t1_valid", 32'(m_tvalid), 32'd1);
            chk("t1_data",  32'(m_tdata),  32'(e1[i]));
            chk("t1_last",  32'(m_tlast),  32'(i == 12));
            if (i <= 11) chk("t1_held_s_tready", 32'(s_tready), 32'd0);
        end
        chk("t1_hs_once_during_send", 32'(hs), 32'd1);

        // Held word with NUL padding: only non-NUL chars then CR/LF.
        exp_d.delete(); exp_l.delete();
        model_push(w2);
        collect_string(60);
        compare_stream("t2");
        chk("t2_hs_total", 32'(hs), 32'd2);

        // No-terminator instance, all-zero word: one forced 0x00 byte with tlast.
        @(negedge aclk);
        b_s_tdata = wz; b_s_tvalid = 1'b1;
        @(negedge aclk);
        b_s_tvalid = 1'b0;
        begin
            int nb;
            logic [7:0] bd;
            logic bl;
            nb = 0; bd = 8'hFF; bl = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge aclk);
                if (b_m_tvalid) begin
                    nb++;
                    bd = b_m_tdata;
                    bl = b_m_tlast;
                end
            end
            chk("t3_byte_count", 32'(nb), 32'd1);
            chk("t3_byte_data",  32'(bd), 32'd0);
            chk("t3_byte_last",  32'(bl), 32'd1);
            chk("t3_s_tready",   32'(b_s_tready), 32'd1);
        end

        // Mid-string reset after 4 bytes, then a fresh word starts at its char 0.
        s_tdata = w1; s_tvalid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("t4_pre_rst_data", 32'(m_tdata), 32'(e1[3]));
        #2 arstn = 1'b0;
        #1;
        chk("t4_async_tvalid", 32'(m_tvalid), 32'd0);
        chk("t4_async_tdata",  32'(m_tdata),  32'd0);
        chk("t4_async_tlast",  32'(m_tlast),  32'd0);
        chk("t4_async_tready", 32'(s_tready), 32'd0);
        @(negedge aclk);
        arstn = 1'b1;
        @(negedge aclk);
        chk("t4_rel_tready", 32'(s_tready), 32'd1);
        chk("t4_rel_tvalid", 32'(m_tvalid), 32'd0);
        s_tdata = w3; s_tvalid = 1'b1;
        exp_d.delete(); exp_l.delete();
        model_push(w3);
        collect_string(60);
        compare_stream("t4");

        // Random backpressure, back-to-back words with tvalid held.
        @(negedge aclk);
        exp_d.delete(); exp_l.delete();
        rx_d.delete(); rx_l.delete();
        model_push(w1); model_push(w2); model_push(wz); model_push(w3);
        begin
            int stall_bad;
            int got_tl;
            int prod_to;
            stall_bad = 0; got_tl = 0; prod_to = 0;
            fork
                begin
                    logic [87:0] words[4];
                    int guard;
                    words[0] = w1; words[1] = w2; words[2] = wz; words[3] = w3;
                    for (int w = 0; w < 4; w++) begin
                        s_tdata = words[w];
                        s_tvalid = 1'b1;
                        guard = 0;
                        while (!s_tready && guard < 500) begin
                            @(negedge aclk);
                            guard++;
                        end
                        if (guard >= 500) prod_to++;
                        @(negedge aclk);
                    end
                    s_tvalid = 1'b0;
                end
                begin
                    logic held;
                    logic [7:0] hd;
                    logic hl;
                    logic rdy;
                    held = 1'b0; hd = 8'h00; hl = 1'b0;
                    for (int c = 0; c < 3000 && got_tl < 4; c++) begin
                        @(negedge aclk);
                        if (held && !(m_tvalid && m_tdata == hd && m_tlast == hl)) stall_bad++;
                        rdy = 1'($urandom_range(0, 1));
                        m_tready = rdy;
                        held = 1'b0;
                        if (m_tvalid) begin
                            if (rdy) begin
                                rx_d.push_back(m_tdata);
                                rx_l.push_back(m_tlast);
                                if (m_tlast) got_tl++;
                            end else begin
                                held = 1'b1;
                                hd = m_tdata;
                                hl = m_tlast;
                            end
                        end
                    end
                end
            join
            @(negedge aclk);
            m_tready = 1'b1;
            chk("t5_producer_timeout", 32'(prod_to), 32'd0);
            chk("t5_stall_stable", 32'(stall_bad), 32'd0);
            chk("t5_tlast_count", 32'(got_tl), 32'd4);
            compare_stream("t5");
        end

        repeat (5) @(negedge aclk);
        chk("t5_idle_after", 32'(m_tvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
